// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the round-robin uart_tx arbiter.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  // Elaboration-time ceil(log2(n)); used to size the grant index.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotating-priority picker: first valid index after i_last_grant, with wrap.
module uart_rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int P_REQ_NUM = 4,
  parameter int P_GW      = 2
) (
  input  logic [P_REQ_NUM-1:0] i_req_valid,
  input  logic [P_GW-1:0]      i_last_grant,
  output logic [P_GW-1:0]      o_winner,
  output logic                 o_any_valid
);

  logic [P_GW:0]   sum;
  logic [P_GW-1:0] idx;

  // Scan from farthest to nearest so the nearest valid index is written last.
  always_comb begin
    o_winner    = '0;
    o_any_valid = |i_req_valid;
    sum         = '0;
    idx         = '0;
    for (int i = P_REQ_NUM; i >= 1; i--) begin
      sum = {1'b0, i_last_grant} + (P_GW+1)'(i);
      if (sum >= (P_GW+1)'(P_REQ_NUM)) sum = sum - (P_GW+1)'(P_REQ_NUM);
      idx = sum[P_GW-1:0];
      if (i_req_valid[idx]) o_winner = idx;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte channel between P_REQ_NUM requesters.
// Define UART_TX_ARB_PKT_LOCK_EN to hold the grant until the byte flagged last.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int P_REQ_NUM    = 4,
  parameter int P_DATA_WIDTH = 8
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [P_REQ_NUM*P_DATA_WIDTH-1:0] i_req_data,
  input  logic [P_REQ_NUM-1:0]              i_req_valid,
  input  logic [P_REQ_NUM-1:0]              i_req_last,
  output logic [P_REQ_NUM-1:0]              o_req_ready,
  output logic [P_DATA_WIDTH-1:0]           o_tx_data,
  output logic                              o_tx_valid,
  input  logic                              i_tx_ready,
  output logic [clog2(P_REQ_NUM)-1:0]       o_grant_id,
  output logic                              o_busy
);

  localparam int GW = clog2(P_REQ_NUM);

  // Requester side: o_req_ready is asserted only in LOAD, one-hot on the grant;
  // a byte moves when ready & valid at a clock edge. Sink side: o_tx_valid stays
  // high with stable data until sampled together with i_tx_ready.
  state_t                  state_q, state_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic [GW-1:0]           last_grant_q, last_grant_d;
  logic [P_DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;
  logic [GW-1:0]           winner;
  logic                    any_valid;
  logic [P_DATA_WIDTH-1:0] sel_data;
  logic                    sel_valid;
  logic                    sel_last;
  logic [P_REQ_NUM-1:0]    grant_onehot;

`ifdef UART_TX_ARB_PKT_LOCK_EN
  logic last_q, last_d;
  logic pkt_q, pkt_d;
`else
  logic unused_last;
  assign unused_last = ^i_req_last ^ sel_last;
`endif

  uart_rr_pick #(
    .P_REQ_NUM (P_REQ_NUM),
    .P_GW      (GW)
  ) u_pick (
    .i_req_valid  (i_req_valid),
    .i_last_grant (last_grant_q),
    .o_winner     (winner),
    .o_any_valid  (any_valid)
  );

  always_comb begin
    sel_data     = '0;
    sel_valid    = 1'b0;
    sel_last     = 1'b0;
    grant_onehot = '0;
    for (int k = 0; k < P_REQ_NUM; k++) begin
      if (grant_q == GW'(k)) begin
        sel_data        = i_req_data[k*P_DATA_WIDTH +: P_DATA_WIDTH];
        sel_valid       = i_req_valid[k];
        sel_last        = i_req_last[k];
        grant_onehot[k] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    o_req_ready  = '0;
`ifdef UART_TX_ARB_PKT_LOCK_EN
    last_d       = last_q;
    pkt_d        = pkt_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_d = winner;
          state_d = LOAD;
        end
      end
      LOAD: begin
        o_req_ready = grant_onehot;
        if (sel_valid) begin
          tx_data_d  = sel_data;
          tx_valid_d = 1'b1;
          state_d    = SEND;
`ifdef UART_TX_ARB_PKT_LOCK_EN
          last_d     = sel_last;
`endif
        end else begin
`ifdef UART_TX_ARB_PKT_LOCK_EN
          // Mid-packet the grant is held while the requester stalls.
          if (!pkt_q) state_d = IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
      SEND: begin
        if (i_tx_ready) begin
          tx_valid_d = 1'b0;
`ifdef UART_TX_ARB_PKT_LOCK_EN
          pkt_d = !last_q;
          if (last_q) begin
            last_grant_d = grant_q;
            state_d      = IDLE;
          end else begin
            state_d = LOAD;
          end
`else
          last_grant_d = grant_q;
          state_d      = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(P_REQ_NUM - 1);
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
`ifdef UART_TX_ARB_PKT_LOCK_EN
      last_q       <= 1'b0;
      pkt_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
`ifdef UART_TX_ARB_PKT_LOCK_EN
      last_q       <= last_d;
      pkt_q        <= pkt_d;
`endif
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
  assign o_grant_id = grant_q;
  assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester queues, a modelled uart_tx ready,
// and a scoreboard of expected {grant, byte} pairs in issue order.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           i_clk = 1'b0;
  logic           i_rst = 1'b1;
  logic [N*W-1:0] i_req_data = '0;
  logic [N-1:0]   i_req_valid = '0;
  logic [N-1:0]   i_req_last = '0;
  logic [N-1:0]   o_req_ready;
  logic [W-1:0]   o_tx_data;
  logic           o_tx_valid;
  logic           i_tx_ready = 1'b1;
  logic [1:0]     o_grant_id;
  logic           o_busy;

  uart_tx_arbiter #(
    .P_REQ_NUM    (N),
    .P_DATA_WIDTH (W)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_data  (i_req_data),
    .i_req_valid (i_req_valid),
    .i_req_last  (i_req_last),
    .o_req_ready (o_req_ready),
    .o_tx_data   (o_tx_data),
    .o_tx_valid  (o_tx_valid),
    .i_tx_ready  (i_tx_ready),
    .o_grant_id  (o_grant_id),
    .o_busy      (o_busy)
  );

  // clock / watchdog
  always #5 i_clk = ~i_clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // bench state
  logic [8:0]   rq[N][$];   // per-requester {last, data}
  logic [9:0]   exp_q[$];   // expected {grant, data} in issue order
  logic [N-1:0] man_valid;
  logic         hold_low;
  int           gap, busy;
  int           n_vec, n_err;
  logic [N-1:0] smp_ready;
  logic         smp_txv, smp_busy;
  logic [W-1:0] smp_txd;
  logic [1:0]   smp_gid;

  typedef struct packed {
    logic [1:0] prime;  // requester whose byte sets the starting last grant
    logic [3:0] mask;   // requesters presenting one byte simultaneously
    logic [2:0] n;      // expected number of issued bytes
    logic [7:0] ord;    // expected grant order, 2 bits each, first at LSB
  } vec_t;

  vec_t vt[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (rq[k].size() > 0) begin
        i_req_valid[k]       = 1'b1;
        i_req_data[k*W +: W] = rq[k][0][7:0];
        i_req_last[k]        = rq[k][0][8];
      end else begin
        i_req_valid[k]       = man_valid[k];
        i_req_data[k*W +: W] = 8'hEE;
        i_req_last[k]        = 1'b1;
      end
    end
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic l);
    rq[k].push_back({l, d});
  endtask

  task automatic expect_byte(input int g, input logic [7:0] d);
    exp_q.push_back({2'(g), d});
  endtask

  function automatic int pending();
    int p;
    p = exp_q.size();
    for (int k = 0; k < N; k++) p += rq[k].size();
    return p;
  endfunction

  // One clock: sample at negedge, score, then advance requesters and the sink model.
  task automatic cycle();
    logic [N-1:0] acc;
    logic         tx_acc;
    logic [9:0]   e;
    @(negedge i_clk);
    smp_ready = o_req_ready;
    smp_txv   = o_tx_valid;
    smp_txd   = o_tx_data;
    smp_busy  = o_busy;
    smp_gid   = o_grant_id;
    acc       = o_req_ready & i_req_valid;
    tx_acc    = o_tx_valid & i_tx_ready;
    check("ready_onehot", 32'($countones(o_req_ready) <= 1), 32'd1);
    if (tx_acc) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL tx_unexpected: got %0h expected nothing at %0t", {o_grant_id, o_tx_data}, $time);
      end else begin
        e = exp_q.pop_front();
        check("tx_byte", 32'({o_grant_id, o_tx_data}), 32'(e));
      end
    end
    @(posedge i_clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (acc[k] && rq[k].size() > 0) void'(rq[k].pop_front());
    end
    if (tx_acc) begin
      gap  = 1;
      busy = $urandom_range(0, 4);
    end else if (gap != 0) begin
      gap = 0;
    end else if (busy > 0) begin
      busy--;
    end
    i_tx_ready = !hold_low && (gap != 0 || busy == 0);
    drive();
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (pending() > 0 && t < 2000) begin
      cycle();
      t++;
    end
    check({name, "_drain"}, 32'(pending()), 32'd0);
    repeat (4) cycle();
  endtask

  // clock / reset block
  task automatic do_reset();
    i_rst     = 1'b1;
    for (int k = 0; k < N; k++) rq[k].delete();
    exp_q.delete();
    man_valid = '0;
    hold_low  = 1'b0;
    gap       = 0;
    busy      = 0;
    drive();
    #1;
    check("rst_tx_valid", 32'(o_tx_valid), 32'd0);
    check("rst_tx_data", 32'(o_tx_data), 32'd0);
    check("rst_req_ready", 32'(o_req_ready), 32'd0);
    check("rst_grant_id", 32'(o_grant_id), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    i_tx_ready = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
  endtask

  task automatic prime(input int p);
    push(p, 8'(8'hF0 + p), 1'b1);
    expect_byte(p, 8'(8'hF0 + p));
    drive();
    wait_drain("prime");
  endtask

  initial begin
    logic [7:0] ord;
    int         id;
    n_vec = 0;
    n_err = 0;
    man_valid = '0;
    hold_low  = 1'b0;
    gap = 0;
    busy = 0;

    vt[0] = '{prime: 2'd3, mask: 4'b1111, n: 3'd4, ord: 8'b11_10_01_00};
    vt[1] = '{prime: 2'd0, mask: 4'b1111, n: 3'd4, ord: 8'b00_11_10_01};
    vt[2] = '{prime: 2'd1, mask: 4'b0101, n: 3'd2, ord: 8'b00_00_00_10};
    vt[3] = '{prime: 2'd2, mask: 4'b0101, n: 3'd2, ord: 8'b00_00_10_00};
    vt[4] = '{prime: 2'd3, mask: 4'b1000, n: 3'd1, ord: 8'b00_00_00_11};
    vt[5] = '{prime: 2'd3, mask: 4'b1001, n: 3'd2, ord: 8'b00_00_11_00};
    vt[6] = '{prime: 2'd1, mask: 4'b0010, n: 3'd1, ord: 8'b00_00_00_01};
    vt[7] = '{prime: 2'd0, mask: 4'b0110, n: 3'd2, ord: 8'b00_00_10_01};

    do_reset();

    // Single byte latency: valid at T, ready at T+1 only, tx_valid at T+2.
    repeat (3) cycle();
    push(0, 8'h55, 1'b1);
    expect_byte(0, 8'h55);
    drive();
    cycle();
    check("lat_t_ready", 32'(smp_ready), 32'd0);
    check("lat_t_txv", 32'(smp_txv), 32'd0);
    cycle();
    check("lat_t1_ready", 32'(smp_ready), 32'b0001);
    check("lat_t1_txv", 32'(smp_txv), 32'd0);
    cycle();
    check("lat_t2_ready", 32'(smp_ready), 32'd0);
    check("lat_t2_txv", 32'(smp_txv), 32'd1);
    check("lat_t2_txd", 32'(smp_txd), 32'h55);
    wait_drain("latency");

    // Table of arbitration cases from a chosen starting grant.
    for (int i = 0; i < 8; i++) begin
      prime(int'(vt[i].prime));
      for (int k = 0; k < N; k++) begin
        if (vt[i].mask[k]) push(k, 8'(16 * i + k), 1'b1);
      end
      ord = vt[i].ord;
      for (int j = 0; j < int'(vt[i].n); j++) begin
        id = int'(ord[2*j +: 2]);
        expect_byte(id, 8'(16 * i + id));
      end
      drive();
      wait_drain("table");
    end

    // All four requesters, requester 0 holding a second byte.
    do_reset();
    push(0, 8'hA0, 1'b1);
    push(0, 8'hA0, 1'b1);
    push(1, 8'hA1, 1'b1);
    push(2, 8'hA2, 1'b1);
    push(3, 8'hA3, 1'b1);
    expect_byte(0, 8'hA0);
    expect_byte(1, 8'hA1);
    expect_byte(2, 8'hA2);
    expect_byte(3, 8'hA3);
    expect_byte(0, 8'hA0);
    drive();
    wait_drain("rr_all");

    // Sink stalled for 20 cycles in SEND.
    do_reset();
    hold_low   = 1'b1;
    i_tx_ready = 1'b0;
    push(2, 8'h3C, 1'b1);
    push(1, 8'h3D, 1'b1);
    expect_byte(1, 8'h3D);
    expect_byte(2, 8'h3C);
    drive();
    cycle();
    cycle();
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("stall_txv", 32'(smp_txv), 32'd1);
      check("stall_txd", 32'(smp_txd), 32'h3D);
      check("stall_ready", 32'(smp_ready), 32'd0);
    end
    hold_low = 1'b0;
    wait_drain("stall");

    // Packet of three bytes from requester 1 against a single byte from requester 0.
    do_reset();
    prime(0);
    push(1, 8'h11, 1'b0);
    push(1, 8'h12, 1'b0);
    push(1, 8'h13, 1'b1);
    push(0, 8'h01, 1'b1);
    expect_byte(1, 8'h11);
`ifdef UART_TX_ARB_PKT_LOCK_EN
    expect_byte(1, 8'h12);
    expect_byte(1, 8'h13);
    expect_byte(0, 8'h01);
`else
    expect_byte(0, 8'h01);
    expect_byte(1, 8'h12);
    expect_byte(1, 8'h13);
`endif
    drive();
    wait_drain("packet");

    // Reset while a byte is held in SEND; the byte is dropped.
    do_reset();
    hold_low   = 1'b1;
    i_tx_ready = 1'b0;
    push(1, 8'h77, 1'b1);
    drive();
    cycle();
    cycle();
    cycle();
    check("midrst_pre_txv", 32'(smp_txv), 32'd1);
    check("midrst_pre_busy", 32'(smp_busy), 32'd1);
    do_reset();
    push(0, 8'h50, 1'b1);
    push(2, 8'h52, 1'b1);
    expect_byte(0, 8'h50);
    expect_byte(2, 8'h52);
    drive();
    wait_drain("after_rst");

    // Requester 3 withdraws during LOAD: no transfer, last grant kept at 2.
    do_reset();
    prime(2);
    man_valid[3] = 1'b1;
    drive();
    cycle();
    man_valid[3] = 1'b0;
    drive();
    cycle();
    check("drop_ready", 32'(smp_ready), 32'b1000);
    check("drop_gid", 32'(smp_gid), 32'd3);
    check("drop_busy_load", 32'(smp_busy), 32'd1);
    check("drop_txv_load", 32'(smp_txv), 32'd0);
    cycle();
    check("drop_busy_idle", 32'(smp_busy), 32'd0);
    check("drop_txv_idle", 32'(smp_txv), 32'd0);
    push(0, 8'h60, 1'b1);
    push(3, 8'h63, 1'b1);
    expect_byte(3, 8'h63);
    expect_byte(0, 8'h60);
    drive();
    wait_drain("drop");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
